// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner_if
// Description : Bundles the datapath-facing control inputs and the
//               board-facing display outputs of the 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scanner_if #(
   parameter int NUM_DIGITS   = 4,
   parameter int BRIGHT_WIDTH = 3
);
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    lzs_en;
   logic [BRIGHT_WIDTH-1:0] brightness;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_tick;

   // Datapath side: supplies values, observes the display pins
   modport master (
      output digits, dp_in, blank, lzs_en, brightness,
      input  seg, dp, an, frame_tick
   );

   // Scanner side
   modport slave (
      input  digits, dp_in, blank, lzs_en, brightness,
      output seg, dp, an, frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner
// Description : Time-multiplexed N-digit common-anode 7-segment driver with
//               per-frame snapshot, hex decode, dp/blank control, leading-zero
//               suppression and PWM brightness. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BRIGHT_WIDTH = 3
) (
   input  wire logic          clk,
   input  wire logic          reset,
   seven_seg_scanner_if.slave bus
);

   localparam int c_STEPS = 1 << BRIGHT_WIDTH;
   localparam int c_STEP  = REFRESH_DIV / c_STEPS;
   localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [c_CNT_W-1:0]    c_CNT_LAST  = c_CNT_W'(REFRESH_DIV - 1);
   localparam logic [c_IDX_W-1:0]    c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] c_DIG0_MASK = ~(NUM_DIGITS'(1));

   // Reject parameter sets for which the PWM step would not be an integer
   if (NUM_DIGITS < 1 || REFRESH_DIV < c_STEPS || (REFRESH_DIV % c_STEPS) != 0) begin : g_param_check
      $error("seven_seg_scanner: REFRESH_DIV must be a multiple of 2**BRIGHT_WIDTH, at least 2**BRIGHT_WIDTH, and NUM_DIGITS >= 1");
   end

   logic [c_CNT_W-1:0]      r_cnt;
   logic [c_IDX_W-1:0]      r_idx;
   logic [4*NUM_DIGITS-1:0] r_snap_digits;
   logic [NUM_DIGITS-1:0]   r_snap_dp;
   logic [NUM_DIGITS-1:0]   r_snap_blank;
   logic                    r_snap_lzs;
   logic [BRIGHT_WIDTH-1:0] r_snap_bright;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame_tick;

   logic                    w_frame_start;
   logic [4*NUM_DIGITS-1:0] w_cur_digits;
   logic [NUM_DIGITS-1:0]   w_cur_dp;
   logic [NUM_DIGITS-1:0]   w_cur_blank;
   logic                    w_cur_lzs;
   logic [BRIGHT_WIDTH-1:0] w_cur_bright;
   logic [3:0]              w_nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   w_zero_from;
   logic [NUM_DIGITS-1:0]   w_suppress;
   logic [3:0]              w_nib_sel;
   logic [6:0]              w_dec;
   logic [31:0]             w_on_limit;
   logic                    w_pwm_on;
   logic [6:0]              w_seg_next;
   logic                    w_dp_next;
   logic [NUM_DIGITS-1:0]   w_an_next;

   assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

   // On the frame-start cycle the live inputs are used directly so the very
   // first output cycle of the frame already reflects the new snapshot.
   assign w_cur_digits = w_frame_start ? bus.digits     : r_snap_digits;
   assign w_cur_dp     = w_frame_start ? bus.dp_in      : r_snap_dp;
   assign w_cur_blank  = w_frame_start ? bus.blank      : r_snap_blank;
   assign w_cur_lzs    = w_frame_start ? bus.lzs_en     : r_snap_lzs;
   assign w_cur_bright = w_frame_start ? bus.brightness : r_snap_bright;

   // Prescaler and digit index: cnt wraps every slot, idx steps per slot
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
      end else begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

   // Capture all display controls once per frame
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap_digits <= '0;
         r_snap_dp     <= '0;
         r_snap_blank  <= '0;
         r_snap_lzs    <= 1'b0;
         r_snap_bright <= '0;
      end else if (w_frame_start) begin
         r_snap_digits <= bus.digits;
         r_snap_dp     <= bus.dp_in;
         r_snap_blank  <= bus.blank;
         r_snap_lzs    <= bus.lzs_en;
         r_snap_bright <= bus.brightness;
      end
   end

   // w_zero_from[k]: nibble k and every higher nibble are zero
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
      assign w_nib[k] = w_cur_digits[4*k +: 4];
      if (k == NUM_DIGITS - 1) begin : g_top
         assign w_zero_from[k] = (w_nib[k] == 4'h0);
      end else begin : g_mid
         assign w_zero_from[k] = (w_nib[k] == 4'h0) && w_zero_from[k+1];
      end
   end

   // Digit 0 is never suppressed so an all-zero value still reads "0"
   assign w_suppress = w_cur_lzs ? (w_zero_from & c_DIG0_MASK) : '0;
   assign w_nib_sel  = w_nib[r_idx];

   // Anode is on for the first (brightness+1) PWM steps of each slot
   assign w_on_limit = (32'(w_cur_bright) + 32'd1) * 32'(c_STEP);
   assign w_pwm_on   = (32'(r_cnt) < w_on_limit);

   // Hex to active-low {g,f,e,d,c,b,a}
   always_comb begin
      w_dec = 7'h7F;
      case (w_nib_sel)
         4'h0: w_dec = 7'b1000000;
         4'h1: w_dec = 7'b1111001;
         4'h2: w_dec = 7'b0100100;
         4'h3: w_dec = 7'b0110000;
         4'h4: w_dec = 7'b0011001;
         4'h5: w_dec = 7'b0010010;
         4'h6: w_dec = 7'b0000010;
         4'h7: w_dec = 7'b1111000;
         4'h8: w_dec = 7'b0000000;
         4'h9: w_dec = 7'b0010000;
         4'hA: w_dec = 7'b0001000;
         4'hB: w_dec = 7'b0000011;
         4'hC: w_dec = 7'b1000110;
         4'hD: w_dec = 7'b0100001;
         4'hE: w_dec = 7'b0000110;
         4'hF: w_dec = 7'b0001110;
         default: w_dec = 7'h7F;
      endcase
   end

   // Next display pin values for the current slot; dark unless lit
   always_comb begin
      w_an_next  = '1;
      w_seg_next = 7'h7F;
      w_dp_next  = 1'b1;
      if (!w_cur_blank[r_idx] && w_pwm_on) begin
         if (!w_suppress[r_idx]) begin
            w_an_next  = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_next = w_dec;
            w_dp_next  = ~w_cur_dp[r_idx];
         end else if (w_cur_dp[r_idx]) begin
            // Suppressed digit keeps its decimal point visible
            w_an_next  = ~(NUM_DIGITS'(1) << r_idx);
            w_dp_next  = 1'b0;
         end
      end
   end

   // Register every output so anode and segment changes are glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         r_an         <= '1;
         r_seg        <= 7'h7F;
         r_dp         <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_an         <= w_an_next;
         r_seg        <= w_seg_next;
         r_dp         <= w_dp_next;
         r_frame_tick <= w_frame_start;
      end
   end

   assign bus.an         = r_an;
   assign bus.seg        = r_seg;
   assign bus.dp         = r_dp;
   assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scanner
// Description : Directed self-checking bench for seven_seg_scanner
//               (4 digits, 8 cycles per slot, 3-bit brightness).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BW = 3;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [3:0] an_tab [4];

   seven_seg_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_WIDTH(BW)) bus ();

   seven_seg_scanner #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BRIGHT_WIDTH(BW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle away from the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es,
                      input logic ed, input logic ef);
      checks++;
      assert (bus.an === ea && bus.seg === es && bus.dp === ed && bus.frame_tick === ef)
      else begin
         errors++;
         $error("FAIL %s: an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                tag, bus.an, bus.seg, bus.dp, bus.frame_tick, ea, es, ed, ef);
      end
   endtask

   // Check slot cycles first_c..last_c; lit digits are on for on_cyc cycles
   task automatic chk_slot(input string tag, input int slot, input int first_c, input int last_c,
                           input logic [6:0] seg_v, input logic lit, input logic dp_v,
                           input int on_cyc);
      for (int c = first_c; c <= last_c; c++) begin
         logic on;
         step();
         on = lit && (c < on_cyc);
         chk(tag, on ? an_tab[slot] : 4'hF, on ? seg_v : 7'h7F, on ? dp_v : 1'b1,
             (slot == 0) && (c == 0));
      end
   endtask

   initial begin
      an_tab[0] = 4'b1110;
      an_tab[1] = 4'b1101;
      an_tab[2] = 4'b1011;
      an_tab[3] = 4'b0111;

      reset          = 1'b1;
      bus.digits     = 16'h1A2F;
      bus.dp_in      = 4'b0000;
      bus.blank      = 4'b0000;
      bus.lzs_en     = 1'b0;
      bus.brightness = 3'd7;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
      end
      reset = 1'b0;

      // Basic scan of 1A2F at full brightness
      chk_slot("scan_d0", 0, 0, 7, 7'b0001110, 1'b1, 1'b1, 8);
      chk_slot("scan_d1", 1, 0, 7, 7'b0100100, 1'b1, 1'b1, 8);
      chk_slot("scan_d2", 2, 0, 7, 7'b0001000, 1'b1, 1'b1, 8);
      chk_slot("scan_d3", 3, 0, 7, 7'b1111001, 1'b1, 1'b1, 8);
      step();
      chk("tick_period", 4'b1110, 7'b0001110, 1'b1, 1'b1);

      // Brightness 2 and dp on digit 0, effective from the following frame
      bus.brightness = 3'd2;
      bus.dp_in      = 4'b0001;
      repeat (31) step();
      chk_slot("pwm_d0", 0, 0, 7, 7'b0001110, 1'b1, 1'b0, 3);
      chk_slot("pwm_d1", 1, 0, 7, 7'b0100100, 1'b1, 1'b1, 3);
      chk_slot("pwm_d2", 2, 0, 7, 7'b0001000, 1'b1, 1'b1, 3);
      chk_slot("pwm_d3", 3, 0, 7, 7'b1111001, 1'b1, 1'b1, 3);

      // Leading-zero suppression of 0050
      bus.lzs_en     = 1'b1;
      bus.digits     = 16'h0050;
      bus.brightness = 3'd7;
      bus.dp_in      = 4'b0000;
      chk_slot("lzs_d0", 0, 0, 7, 7'b1000000, 1'b1, 1'b1, 8);
      chk_slot("lzs_d1", 1, 0, 7, 7'b0010010, 1'b1, 1'b1, 8);
      chk_slot("lzs_d2", 2, 0, 7, 7'h7F,      1'b0, 1'b1, 8);
      chk_slot("lzs_d3", 3, 0, 7, 7'h7F,      1'b0, 1'b1, 8);

      // All-zero value: only digit 0 lit; suppressed digit 2 keeps its dp
      bus.digits = 16'h0000;
      bus.dp_in  = 4'b0100;
      chk_slot("lzs0_d0", 0, 0, 7, 7'b1000000, 1'b1, 1'b1, 8);
      chk_slot("lzs0_d1", 1, 0, 7, 7'h7F,      1'b0, 1'b1, 8);
      chk_slot("lzs0_d2", 2, 0, 7, 7'h7F,      1'b1, 1'b0, 8);
      chk_slot("lzs0_d3", 3, 0, 7, 7'h7F,      1'b0, 1'b1, 8);

      // Snapshot: 1234, then 5678 and blank applied mid-frame
      bus.lzs_en = 1'b0;
      bus.dp_in  = 4'b0000;
      bus.digits = 16'h1234;
      chk_slot("snap_d0", 0, 0, 7, 7'b0011001, 1'b1, 1'b1, 8);
      chk_slot("snap_d1a", 1, 0, 2, 7'b0110000, 1'b1, 1'b1, 8);
      bus.digits = 16'h5678;
      bus.blank  = 4'b0100;
      chk_slot("snap_d1b", 1, 3, 7, 7'b0110000, 1'b1, 1'b1, 8);
      chk_slot("snap_d2", 2, 0, 7, 7'b0100100, 1'b1, 1'b1, 8);
      chk_slot("snap_d3", 3, 0, 7, 7'b1111001, 1'b1, 1'b1, 8);
      chk_slot("new_d0", 0, 0, 7, 7'b0000000, 1'b1, 1'b1, 8);
      bus.blank = 4'b0000;
      chk_slot("new_d1", 1, 0, 7, 7'b1111000, 1'b1, 1'b1, 8);
      chk_slot("blank_d2", 2, 0, 7, 7'h7F,    1'b0, 1'b1, 8);
      chk_slot("new_d3", 3, 0, 7, 7'b0010010, 1'b1, 1'b1, 8);

      // Reset asserted while digit 2 is showing
      chk_slot("pre_d0", 0, 0, 7, 7'b0000000, 1'b1, 1'b1, 8);
      chk_slot("pre_d1", 1, 0, 7, 7'b1111000, 1'b1, 1'b1, 8);
      chk_slot("pre_d2", 2, 0, 2, 7'b0000010, 1'b1, 1'b1, 8);
      reset = 1'b1;
      step();
      chk("rst_mid", 4'hF, 7'h7F, 1'b1, 1'b0);
      step();
      chk("rst_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
      reset = 1'b0;
      chk_slot("restart_d0", 0, 0, 7, 7'b0000000, 1'b1, 1'b1, 8);
      chk_slot("restart_d1", 1, 0, 0, 7'b1111000, 1'b1, 1'b1, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It holds a refresh prescaler, a per-frame snapshot of the digit values, and an internal hex decoder. It also provides per-digit decimal-point and blank control, leading-zero suppression and PWM brightness. It sits between the datapath registers and the board display pins, and all of its outputs are registered.

## Interface
- `NUM_DIGITS`, 4: digits scanned, ≥1.
- `REFRESH_DIV`, 100000: clk cycles per digit slot. Must be a multiple of 2^BRIGHT_WIDTH and ≥ 2^BRIGHT_WIDTH; the block raises an elaboration-time error otherwise.
- `BRIGHT_WIDTH`, 3: brightness code width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digits`  in  4*NUM_DIGITS  packed hex nibbles; [3:0] is digit 0 (rightmost).
- `dp_in`  in  NUM_DIGITS  1 lights the decimal point of that digit.
- `blank`  in  NUM_DIGITS  1 forces that digit dark (segments and dp).
- `lzs_en`  in  1  leading-zero suppression enable.
- `brightness`  in  BRIGHT_WIDTH  duty code; 0 is dimmest, all-ones is 100 %.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  NUM_DIGITS  anode enables, active-low, at most one low.
- `frame_tick`  out  1  one-cycle pulse at each frame start.

## Operation
- **Prescaler `cnt`** counts 0..REFRESH_DIV-1 and wraps.
- **Digit index `idx`** advances by 1 when cnt == REFRESH_DIV-1. It wraps from NUM_DIGITS-1 to 0.
- **Frame start** is the cycle with cnt==0 and idx==0. This includes the first cycle after reset deasserts. On that cycle:
  - `digits`, `dp_in`, `blank`, `lzs_en` and `brightness` are captured into snapshot registers.
  - Input changes mid-frame have no effect until the next frame start.
- **Leading-zero suppression.** When snapshot lzs_en=1, digit k is suppressed if its nibble and every higher nibble are 0. Digit 0 is never suppressed, so value 0 shows "0".
  - A suppressed digit is dark, including its dp. Exception: a digit whose snapshot dp_in bit is 1 still shows its dp.
- **Digit dark condition.** The digit is dark when its snapshot blank bit is 1, or when the slot is in the PWM off phase. Dark means `an` all-ones, `seg` 7'h7F and `dp` 1.
- **PWM.** Let STEP = REFRESH_DIV / 2^BRIGHT_WIDTH. The anode is on while cnt < (brightness+1)*STEP, using the snapshot value of brightness.
- **Decoder**, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- **Reset values:** cnt=0, idx=0, snapshot all zero, `an` all-ones, `seg`=7'h7F, `dp`=1, `frame_tick`=0. Reset asserted mid-frame takes effect on the next edge and blanks the display within one cycle.
- **Output latency.** `seg`, `dp` and `an` are registered. The values computed from cnt/idx in cycle t appear in cycle t+1. A new snapshot therefore affects the outputs one cycle after frame start.
- **frame_tick** is high for exactly the one cycle after each frame-start cycle, i.e. aligned with the first output cycle of digit 0. Period = NUM_DIGITS*REFRESH_DIV cycles.
- **NUM_DIGITS=1:** idx stays 0 and a frame equals one slot.
- **Slot boundaries:** no two anodes are low in the same cycle. When `an` switches digits, `seg` and `dp` switch in the same cycle.

## Test plan
- **Reset.** Hold reset 3 cycles, any inputs -> `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_tick`=0 throughout. After release, `frame_tick` pulses at cycle 1.
- **Basic scan.** NUM_DIGITS=4, REFRESH_DIV=8, BRIGHT_WIDTH=3, brightness=7, digits=16'h1A2F -> `an` cycles 1110,1101,1011,0111 for 8 cycles each. `seg` reads F=0001110, 2=0100100, A=0001000, 1=1111001. `frame_tick` period is 32.
- **PWM and dp.** Same setup, brightness=2, dp_in=4'b0001 -> per slot `an` is low for cycles 0–2 (3 of 8), and `dp`=0 only during digit 0's on-time.
- **Leading-zero suppression.** lzs_en=1, digits=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. With digits=16'h0000, only digit 0 lit, showing 0.
- **Snapshot.** Change digits from 16'h1234 to 16'h5678 mid-frame -> the remainder of that frame shows 1234, and the next frame shows 5678. Blank=4'b0100 -> digit 2 `an` stays high for the whole slot.
- **Reset mid-operation.** Assert reset during digit 2 -> outputs go dark on the next cycle. After release, the scan restarts at digit 0 with cnt=0.
